// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_LANES = 4;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Expand byte enables into a bit mask over a full word.
    function automatic logic [WORD_W-1:0] lane_mask(input logic [BYTE_LANES-1:0] be);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int i = 0; i < BYTE_LANES; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with one byte-lane synchronous write port and one combinational read port.
// Optional per-word even parity when DMEM_PARITY_EN is defined.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [BYTE_LANES-1:0] be,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata,
    output logic [WORD_W-1:0]     wr_word,
    output logic                  par_err
);

    logic [WORD_W-1:0] dMem [DEPTH_WORDS];

    assign rdata   = dMem[idx];
    // Word as it will look after the write; used for the response and for parity.
    assign wr_word = (rdata & ~lane_mask(be)) | (wdata & lane_mask(be));

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (be[i]) begin
                    dMem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic par_bits [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            par_bits[idx] <= ^wr_word;
        end
    end

    assign par_err = (^rdata) != par_bits[idx];
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Request/ack data-memory responder: IDLE -> WAIT (WAIT_CYCLES extra cycles) -> RESP.
// Define DMEM_PARITY_EN to enable stored per-word parity checking on reads.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    output logic        ready,
    input  logic        wrEn,
    input  logic [31:0] address,
    input  logic [3:0]  byteEn,
    input  logic [31:0] data_in,
    output logic        ack,
    output logic [31:0] data_out,
    output logic        err,
    output logic        parity_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [WORD_W-1:0]       addr_q, addr_d;
    logic [BYTE_LANES-1:0]   be_q, be_d;
    logic [WORD_W-1:0]       wdata_q, wdata_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    perr_q, perr_d;
    logic [WORD_W-1:0]       dout_q, dout_d;

    logic                    mem_we;
    logic                    bad_addr;
    logic [WORD_W-1:0]       rdata;
    logic [WORD_W-1:0]       wr_word;
    logic                    arr_par_err;

    // Misaligned, or any bit above the word index set, is out of range.
    assign bad_addr = (addr_q[1:0] != 2'b00) || (addr_q[WORD_W-1:IDX_W+2] != '0);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .idx     (addr_q[IDX_W+1:2]),
        .be      (be_q),
        .wdata   (wdata_q),
        .rdata   (rdata),
        .wr_word (wr_word),
        .par_err (arr_par_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        err_d   = err_q;
        perr_d  = perr_q;
        dout_d  = dout_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d    = wrEn;
                    addr_d  = address;
                    be_d    = byteEn;
                    wdata_d = data_in;
                    cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end else begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    err_d   = bad_addr;
                    perr_d  = 1'b0;
                    if (bad_addr) begin
                        dout_d = '0;
                    end else if (wr_q) begin
                        mem_we = 1'b1;
                        dout_d = wr_word;
                    end else begin
                        dout_d = rdata;
                        perr_d = arr_par_err;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            perr_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            perr_q  <= perr_d;
            dout_q  <= dout_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign ack        = ack_q;
    assign data_out   = dout_q;
    assign err        = err_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        ready;
    logic        wrEn;
    logic [31:0] address;
    logic [3:0]  byteEn;
    logic [31:0] data_in;
    logic        ack;
    logic [31:0] data_out;
    logic        err;
    logic        parity_err;

    int          n_checks;
    int          n_errors;
    logic [31:0] model_mem [DEPTH];
    bit          model_par_bad [DEPTH];
    logic [31:0] exp_q [$];

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .ready      (ready),
        .wrEn       (wrEn),
        .address    (address),
        .byteEn     (byteEn),
        .data_in    (data_in),
        .ack        (ack),
        .data_out   (data_out),
        .err        (err),
        .parity_err (parity_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the spec's rules applied to a plain word array.
    task automatic model_access(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] data, output logic [31:0] dout,
                                output logic e, output logic pe);
        int unsigned w;
        logic [31:0] word;
        logic [31:0] lane;
        pe = 1'b0;
        if ((addr % 4) != 0 || addr >= 32'(4 * DEPTH)) begin
            e    = 1'b1;
            dout = 32'h0;
        end else begin
            e    = 1'b0;
            w    = addr / 4;
            word = model_mem[w];
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    lane = 32'hFF << (8 * i);
                    if (be[i]) word = (word & ~lane) | (data & lane);
                end
                model_mem[w]     = word;
                model_par_bad[w] = 1'b0;
            end else begin
                pe = model_par_bad[w];
            end
            dout = word;
        end
    endtask

    // Driver: one full transaction, inputs scrambled while the access is in flight.
    task automatic do_access(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] data);
        logic [31:0] exp_dout;
        logic        exp_err;
        logic        exp_pe;
        int          lat;
        model_access(wr, addr, be, data, exp_dout, exp_err, exp_pe);
        exp_q.push_back(exp_dout);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        req = 1'b1; wrEn = wr; address = addr; byteEn = be; data_in = data;
        @(posedge clk);
        #1;
        req = 1'($urandom); wrEn = 1'($urandom); address = $urandom;
        byteEn = 4'($urandom); data_in = $urandom;
        lat = 0;
        while (!ack && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_ack"}, 32'(ack), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(W + 2));
        check({tag, "_data"}, data_out, exp_q.pop_front());
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_perr"}, 32'(parity_err), 32'(exp_pe));
        @(negedge clk);
        req = 1'b0;
        check({tag, "_ack_drop"}, 32'(ack), 32'd0);
        check({tag, "_hold"}, data_out, exp_dout);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] v;
        int          r;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; req = 1'b0; wrEn = 1'b0; address = '0; byteEn = '0; data_in = '0;

        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            if (i == 0) v = 32'h12345678;
            if (i == 2) v = 32'h0;
            u_dut.u_array.dMem[i] = v;
            model_mem[i]     = v;
            model_par_bad[i] = 1'b0;
`ifdef DMEM_PARITY_EN
            u_dut.u_array.par_bits[i] = ^v;
`endif
        end

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_dout", data_out, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_access("rd0", 1'b0, 32'h0, 4'hF, 32'h0);
        do_access("wr4", 1'b1, 32'h4, 4'hF, 32'h1);
        do_access("rd4", 1'b0, 32'h4, 4'h0, 32'h0);
        do_access("wr8_half", 1'b1, 32'h8, 4'b0011, 32'hFFFFFFFF);
        do_access("rd8", 1'b0, 32'h8, 4'hF, 32'h0);
        do_access("rd_misal", 1'b0, 32'h6, 4'hF, 32'h0);
        do_access("wr_oor", 1'b1, 32'h400, 4'hF, 32'hDEADBEEF);
        do_access("rd_last", 1'b0, 32'h3FC, 4'hF, 32'h0);
        do_access("wr_noop", 1'b1, 32'h4, 4'b0000, 32'hCAFEF00D);
        do_access("rd_noop", 1'b0, 32'h4, 4'hF, 32'h0);

        // Reset in the middle of a write must drop it.
        req = 1'b1; wrEn = 1'b1; address = 32'hC; byteEn = 4'hF; data_in = 32'hAAAAAAAA;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_dout", data_out, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_ack", 32'(ack), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ack", 32'(ack), 32'd0);
        do_access("rdC", 1'b0, 32'hC, 4'hF, 32'h0);

`ifdef DMEM_PARITY_EN
        do_access("wr10", 1'b1, 32'h10, 4'hF, 32'h0000000F);
        u_dut.u_array.par_bits[4] = ~u_dut.u_array.par_bits[4];
        model_par_bad[4] = 1'b1;
        do_access("rd10_par", 1'b0, 32'h10, 4'hF, 32'h0);
`endif

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 1023)) * 4;
            else             a = $urandom;
            do_access("rand", 1'($urandom), a, 4'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, 256, number of 32-bit words stored; power of two, 16..4096.
REQ-002 Parameter WAIT_CYCLES, 2, extra wait cycles per access; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  1  initiator request valid.
REQ-006 ready  output  1  responder idle, can accept req.
REQ-007 wrEn  input  1  1 = write, 0 = read; sampled with req.
REQ-008 address  input  32  byte address; sampled with req.
REQ-009 byteEn  input  4  write byte lanes; bit i selects data_in[8i+7:8i]; ignored on reads.
REQ-010 data_in  input  32  write data; sampled with req.
REQ-011 ack  output  1  one-cycle response strobe.
REQ-012 data_out  output  32  read data; valid while ack=1, held until next ack.
REQ-013 err  output  1  access rejected; valid while ack=1.
REQ-014 parity_err  output  1  stored-parity mismatch on read; valid while ack=1.

Function
REQ-015 FSM states IDLE, WAIT, RESP; ready = (state==IDLE).
REQ-016 IDLE: req=1 at an edge -> latch wrEn/address/byteEn/data_in, load counter with WAIT_CYCLES, go WAIT; req=0 -> stay.
REQ-017 WAIT: counter>0 -> decrement; counter==0 -> perform access at this edge, go RESP.
REQ-018 RESP: ack=1 for exactly one cycle, then IDLE; req is ignored in WAIT and RESP.
REQ-019 Latency: request accepted at edge N -> ack high in the cycle after edge N+WAIT_CYCLES+1; back-to-back throughput one access per WAIT_CYCLES+3 cycles.
REQ-020 Word index = address[log2(DEPTH_WORDS)+1:2].
REQ-021 Error when address[1:0]!=0 or address >= 4*DEPTH_WORDS: no write, data_out=0, err=1.
REQ-022 Write: only lanes with byteEn=1 updated; byteEn=0000 is a legal no-op write, err=0.
REQ-023 Write response: data_out = new full stored word (read-after-write).
REQ-024 Read: data_out = stored word; no memory change.
REQ-025 Inputs changing while not IDLE have no effect on the access in flight.

Reset
REQ-026 rst_n low -> state=IDLE, counter=0, ack=0, err=0, parity_err=0, data_out=0, ready=1.
REQ-027 Memory array is not reset; contents survive rst_n.
REQ-028 Reset during WAIT aborts the access; no write is committed, no ack issued.
REQ-029 Reset deassertion coincident with req: request is not accepted on that edge.

Configuration
REQ-030 Macro DMEM_PARITY_EN defined: one even-parity bit per word, recomputed on every write commit; read mismatch -> parity_err=1 with ack, data still returned.
REQ-031 Macro DMEM_PARITY_EN undefined: no parity storage, parity_err tied 0.

Structure
REQ-032 Package dmem_pkg holds state enum (IDLE/WAIT/RESP), WORD_W=32, BYTE_LANES=4, WAIT_CNT_W=4.
REQ-033 Storage in sub-module dmem_array (one synchronous write port with byte lanes, one read port, optional parity bit); FSM and checks in dmem_responder.
REQ-034 Storage array hierarchically accessible as dmem_array instance member dMem for $readmemb/$writememb preload and dump.

Verification
REQ-035 Preload dMem[0]=0x12345678; read 0x00000000 -> ack after WAIT_CYCLES+2 edges, data_out=0x12345678, err=0.
REQ-036 Write 0x00000001 to 0x00000004, byteEn=1111; read 0x4 -> 0x00000001.
REQ-037 dMem[2]=0; write 0xFFFFFFFF to 0x8, byteEn=0011 -> data_out=0x0000FFFF; read 0x8 -> 0x0000FFFF.
REQ-038 Read 0x00000006 and write to 0x00000400 (DEPTH_WORDS=256) -> err=1, data_out=0, memory unchanged.
REQ-039 Write 0xAAAAAAAA to 0xC, pull rst_n low during WAIT -> no ack; read 0xC returns prior value.
REQ-040 DMEM_PARITY_EN: write 0x0000000F to 0x10, force stored parity bit inverted, read 0x10 -> parity_err=1, data_out=0x0000000F.
